// File: rtl/video_mixer_sl.sv
// Video mixer output stage: colour expansion to 8 bits, freeze blanking, frame-stable
// scanline dimming, pixel-enable recovery and DE generation. Optional VIDEO_MIXER_SL_MEASURE_EN
// adds active_w/active_h measurement outputs.
module video_mixer_sl #(
  parameter int COLOR_BITS = 8,
  parameter int SL_PARITY  = 1
) (
  input  logic                  CLK_VIDEO,
  input  logic                  RESET,
  input  logic                  ce_pix,
  input  logic                  HDMI_FREEZE,
  input  logic [1:0]            scanlines,
  input  logic [COLOR_BITS-1:0] R,
  input  logic [COLOR_BITS-1:0] G,
  input  logic [COLOR_BITS-1:0] B,
  input  logic                  HSync,
  input  logic                  VSync,
  input  logic                  HBlank,
  input  logic                  VBlank,
  output logic                  CE_PIXEL,
  output logic [7:0]            VGA_R,
  output logic [7:0]            VGA_G,
  output logic [7:0]            VGA_B,
  output logic                  VGA_HS,
  output logic                  VGA_VS,
  output logic                  VGA_DE
`ifdef VIDEO_MIXER_SL_MEASURE_EN
  ,
  output logic [11:0]           active_w,
  output logic [11:0]           active_h
`endif
);

  localparam logic SL_PAR = SL_PARITY[0];

  function automatic logic [7:0] expand(input logic [COLOR_BITS-1:0] c);
    logic [7:0] e;
    e = '0;
    for (int i = 0; i < 8; i++) e[7-i] = c[COLOR_BITS-1-(i%COLOR_BITS)];
    return e;
  endfunction

  function automatic logic [7:0] dim(input logic [7:0] c, input logic [1:0] m);
    logic [7:0] d;
    case (m)
      2'd1:    d = c - {2'b00, c[7:2]};
      2'd2:    d = {1'b0, c[7:1]};
      2'd3:    d = {2'b00, c[7:2]};
      default: d = c;
    endcase
    return d;
  endfunction

  logic       frz_meta, frz;
  logic       old_hs, old_vs, old_ce;
  logic       parity;
  logic [1:0] sl_mode;
  logic       ce_osc, fs_osc;
  logic [7:0] r1, g1, b1, r2, g2, b2;
  logic       hs1, vs1, hb1, vb1, hs2, vs2, hb2, vb2;
  logic       hde, hde_prev;
  logic       hs_rise, vs_rise, dim_en;

  assign hs_rise = HSync & ~old_hs;
  assign vs_rise = VSync & ~old_vs;
  assign dim_en  = (parity == SL_PAR) && (sl_mode != 2'd0);
  assign hde     = ~hb2 & ~vb2;

  // Parity, mode latch and CE recovery all key off input-side edges.
  always_ff @(posedge CLK_VIDEO or posedge RESET) begin
    if (RESET) begin
      frz_meta <= 1'b0;
      frz      <= 1'b0;
      old_hs   <= 1'b0;
      old_vs   <= 1'b0;
      old_ce   <= 1'b0;
      parity   <= 1'b0;
      sl_mode  <= 2'd0;
      ce_osc   <= 1'b0;
      fs_osc   <= 1'b0;
      CE_PIXEL <= 1'b0;
    end else begin
      frz_meta <= HDMI_FREEZE;
      frz      <= frz_meta;
      old_hs   <= HSync;
      old_vs   <= VSync;
      old_ce   <= ce_pix;
      if (vs_rise) begin
        parity  <= 1'b0;
        sl_mode <= scanlines;
      end else if (hs_rise) begin
        parity  <= ~parity;
      end
      if (vs_rise) begin
        fs_osc <= ce_osc;
        ce_osc <= 1'b0;
      end else if (ce_pix != old_ce) begin
        ce_osc <= 1'b1;
      end
      CE_PIXEL <= fs_osc ? (~old_ce & ce_pix) : ce_pix;
    end
  end

  always_ff @(posedge CLK_VIDEO or posedge RESET) begin
    if (RESET) begin
      r1 <= '0; g1 <= '0; b1 <= '0;
      r2 <= '0; g2 <= '0; b2 <= '0;
      hs1 <= 1'b0; vs1 <= 1'b0; hb1 <= 1'b0; vb1 <= 1'b0;
      hs2 <= 1'b0; vs2 <= 1'b0; hb2 <= 1'b0; vb2 <= 1'b0;
    end else begin
      r1  <= frz ? 8'd0 : expand(R);
      g1  <= frz ? 8'd0 : expand(G);
      b1  <= frz ? 8'd0 : expand(B);
      hs1 <= HSync;
      vs1 <= VSync;
      hb1 <= HBlank;
      vb1 <= VBlank;
      r2  <= dim_en ? dim(r1, sl_mode) : r1;
      g2  <= dim_en ? dim(g1, sl_mode) : g1;
      b2  <= dim_en ? dim(b1, sl_mode) : b1;
      hs2 <= hs1;
      vs2 <= vs1;
      hb2 <= hb1;
      vb2 <= vb1;
    end
  end

  // DE only reloads on an hde change between pixel enables, keeping its edges on pixel boundaries.
  always_ff @(posedge CLK_VIDEO or posedge RESET) begin
    if (RESET) begin
      VGA_R    <= '0;
      VGA_G    <= '0;
      VGA_B    <= '0;
      VGA_HS   <= 1'b0;
      VGA_VS   <= 1'b0;
      VGA_DE   <= 1'b0;
      hde_prev <= 1'b0;
    end else if (CE_PIXEL) begin
      VGA_R    <= r2;
      VGA_G    <= g2;
      VGA_B    <= b2;
      VGA_HS   <= hs2;
      VGA_VS   <= vs2;
      hde_prev <= hde;
      if (hde != hde_prev) VGA_DE <= hde;
    end
  end

`ifdef VIDEO_MIXER_SL_MEASURE_EN
  logic        hs3, vs3, line_act;
  logic [11:0] h_cnt, line_cnt, last_w;
  logic        h_rise2, v_rise2;

  assign h_rise2 = hs2 & ~hs3;
  assign v_rise2 = vs2 & ~vs3;

  // Counted on the stage-2 timing so line boundaries match the hde being counted.
  always_ff @(posedge CLK_VIDEO or posedge RESET) begin
    if (RESET) begin
      hs3      <= 1'b0;
      vs3      <= 1'b0;
      line_act <= 1'b0;
      h_cnt    <= '0;
      line_cnt <= '0;
      last_w   <= '0;
      active_w <= '0;
      active_h <= '0;
    end else begin
      hs3 <= hs2;
      vs3 <= vs2;
      if (h_rise2) begin
        last_w   <= h_cnt;
        h_cnt    <= '0;
        line_act <= 1'b0;
        if (line_act && line_cnt != 12'hFFF) line_cnt <= line_cnt + 12'd1;
      end else if (CE_PIXEL && hde) begin
        if (h_cnt != 12'hFFF) h_cnt <= h_cnt + 12'd1;
        line_act <= 1'b1;
      end
      if (v_rise2) begin
        active_w <= last_w;
        active_h <= line_cnt;
        line_cnt <= '0;
      end
    end
  end
`endif

endmodule
